// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: width constants, bypass select
// encoding and the per-stage destination-register shadow entry.
package pipeline_hazard_controller_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned REG_NUM_WIDTH = 5;

    typedef enum logic [1:0] {
        NO_BYPASS      = 2'd0,
        BYPASS_EXECUTE = 2'd1,
        BYPASS_MEMORY  = 2'd2
    } BypassCtrl;

    typedef struct packed {
        logic                     valid;
        logic                     wr;
        logic [REG_NUM_WIDTH-1:0] rd;
        logic                     isLoad;
    } RegWriteTrack;

endpackage

// File: rtl/pipeline_hazard_controller_bypass.sv
// Per-operand dependency check against the EX/MEM/WB shadow entries.
// CONTROLLER_BYPASS_EN selects forwarding; otherwise every in-flight producer stalls.
module operand_bypass_select
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [REG_NUM_WIDTH-1:0] src,
    input  logic                     srcUsed,
    input  RegWriteTrack             ex,
    input  RegWriteTrack             mem,
    input  RegWriteTrack             wb,
    output BypassCtrl                bypass,
    output logic                     hazard
);

    function automatic logic hits(input RegWriteTrack e, input logic [REG_NUM_WIDTH-1:0] s,
                                  input logic used);
        return used && e.valid && e.wr && (e.rd == s) && (s != '0);
    endfunction

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = hits(ex, src, srcUsed);
    assign mem_hit = hits(mem, src, srcUsed);

`ifdef CONTROLLER_BYPASS_EN
    // Youngest producer wins; only a load still in EX cannot be forwarded.
    always_comb begin
        bypass = NO_BYPASS;
        if (ex_hit)
            bypass = BYPASS_EXECUTE;
        else if (mem_hit)
            bypass = BYPASS_MEMORY;
    end

    assign hazard = ex_hit & ex.isLoad;

    logic unused_track;
    assign unused_track = ^{wb, mem.isLoad};
`else
    logic wb_hit;

    // Register file is not write-through, so a WB producer must stall too.
    assign wb_hit = hits(wb, src, srcUsed);
    assign bypass = NO_BYPASS;
    assign hazard = ex_hit | mem_hit | wb_hit;

    logic unused_track;
    assign unused_track = ^{ex.isLoad, mem.isLoad, wb.isLoad};
`endif

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Controller side of the 5-stage pipeline control interface: shadows EX/MEM/WB
// destinations and drives bypass selects, load-use stall and mispredict flush (CONTROLLER_BYPASS_EN).
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = pipeline_hazard_controller_pkg::ADDR_WIDTH,
    parameter int unsigned REG_NUM_WIDTH = pipeline_hazard_controller_pkg::REG_NUM_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_NUM_WIDTH-1:0] idRs1,
    input  logic [REG_NUM_WIDTH-1:0] idRs2,
    input  logic                     idRs1Used,
    input  logic                     idRs2Used,
    input  logic [REG_NUM_WIDTH-1:0] idRd,
    input  logic                     idWrEn,
    input  logic                     idIsLoad,
    input  logic                     idValid,
    input  logic                     exIsBranch,
    input  logic                     exPredTaken,
    input  logic                     exActualTaken,
    input  logic [ADDR_WIDTH-1:0]    exPredTarget,
    input  logic [ADDR_WIDTH-1:0]    exActualTarget,
    input  logic                     pipelineStall,
    output logic                     isDataHazard,
    output logic                     isBranchPredictMiss,
    output BypassCtrl                op1BypassCtrl,
    output BypassCtrl                op2BypassCtrl
);

    RegWriteTrack ex;
    RegWriteTrack mem;
    RegWriteTrack wb;
    logic         hazard1;
    logic         hazard2;

    operand_bypass_select u_op1 (
        .src     (idRs1),
        .srcUsed (idRs1Used),
        .ex      (ex),
        .mem     (mem),
        .wb      (wb),
        .bypass  (op1BypassCtrl),
        .hazard  (hazard1)
    );

    operand_bypass_select u_op2 (
        .src     (idRs2),
        .srcUsed (idRs2Used),
        .ex      (ex),
        .mem     (mem),
        .wb      (wb),
        .bypass  (op2BypassCtrl),
        .hazard  (hazard2)
    );

    assign isBranchPredictMiss = ex.valid & exIsBranch & ~pipelineStall &
                                 ((exPredTaken != exActualTaken) |
                                  (exActualTaken & (exPredTarget != exActualTarget)));

    // The ID instruction is wrong-path on a mispredict, so its stall is moot.
    assign isDataHazard = idValid & (hazard1 | hazard2) & ~isBranchPredictMiss;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else if (!pipelineStall) begin
            mem <= ex;
            wb  <= mem;
            if (isBranchPredictMiss || isDataHazard)
                ex <= '0;
            else
                ex <= '{valid: idValid, wr: idWrEn, rd: idRd, isLoad: idIsLoad};
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Drives the Controller side of the pipeline control interface in the 5-stage core (IF/ID/EX/MEM/WB).
- Keeps its own shadow of in-flight destination registers for the EX, MEM and WB stages.
- From that shadow it produces the operand bypass selects for the decode stage, a load-use stall (isDataHazard) and the branch-mispredict flush (isBranchPredictMiss).

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- REG_NUM_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- idRs1 / idRs2  in  REG_NUM_WIDTH each  decode-stage source register indices
- idRs1Used / idRs2Used  in  1 each  source operand is actually read
- idRd  in  REG_NUM_WIDTH  decode-stage destination register
- idWrEn  in  1  decode instruction writes rd
- idIsLoad  in  1  decode instruction is a load
- idValid  in  1  decode slot holds a real instruction
- exIsBranch  in  1  EX instruction is a branch/jump
- exPredTaken / exActualTaken  in  1 each  predicted vs resolved direction
- exPredTarget / exActualTarget  in  ADDR_WIDTH each  predicted vs resolved target
- pipelineStall  in  1  global freeze (e.g. dcache miss)
- isDataHazard  out  1  stall IF/ID, bubble into EX
- isBranchPredictMiss  out  1  flush IF/ID, redirect fetch
- op1BypassCtrl / op2BypassCtrl  out  BypassCtrl each  operand source select

Behaviour:
- Shadow entry fields, one entry per stage (ex, mem, wb): valid, wr, rd, isLoad.
- Reset (rst=0, async): all entries cleared. With entries empty, the combinational outputs resolve to isDataHazard=0, isBranchPredictMiss=0, bypass=NO_BYPASS.
- Source match rule: source s matches entry e when all hold:
  - sUsed, e.valid, e.wr
  - e.rd == s
  - s != 0 (x0 never matches)
- Bypass select, combinational, per operand:
  - match ex -> BYPASS_EXECUTE
  - else match mem -> BYPASS_MEMORY
  - else NO_BYPASS
  - The youngest producer wins.
- isDataHazard: idValid & any source matches ex with ex.isLoad. Forced 0 while isBranchPredictMiss=1.
- isBranchPredictMiss = ex.valid & exIsBranch & !pipelineStall & ((exPredTaken != exActualTaken) | (exActualTaken & exPredTarget != exActualTarget)). Combinational, same cycle as EX resolution.
- Update at posedge clk, evaluated in priority order:
  1. pipelineStall=1: all entries hold. isDataHazard still reflects the held state.
  2. isBranchPredictMiss=1: ex <= invalid (wrong-path ID flushed), mem <= ex, wb <= mem.
  3. isDataHazard=1: ex <= invalid (bubble), mem <= ex, wb <= mem.
  4. Otherwise: ex <= {idValid, idWrEn, idRd, idIsLoad}, mem <= ex, wb <= mem.
- Load-use latency: exactly one stall cycle. Next cycle the load sits in mem and the select is BYPASS_MEMORY.
- A flushed slot (ex.valid=0) never raises a mispredict and never causes a hazard.
- Reset asserted mid-operation clears all entries immediately; outputs deassert in the same cycle.

Optional Feature:
- CONTROLLER_BYPASS_EN defined: forwarding as above.
- Undefined:
  - Both bypass outputs are tied to NO_BYPASS.
  - isDataHazard = idValid & any source matches ex, mem or wb, whatever isLoad says.
  - The register file is not write-through, so a WB match also stalls.
  - Mispredict masking and update rules are unchanged.

Decomposition:
- PipelineTypes:
  - BypassCtrl enum {NO_BYPASS, BYPASS_EXECUTE, BYPASS_MEMORY}.
  - Shadow-entry struct RegWriteTrack {valid, wr, rd, isLoad}.
- BasicTypes: ADDR_WIDTH/REG_NUM_WIDTH constants.
- One sub-module, operand_bypass_select: combinational match logic for one operand. Instantiated twice, returns the bypass select and a hazard contribution.

Test Plan:
- add x5 then next-cycle add x6,x5,x1 -> op1BypassCtrl=BYPASS_EXECUTE, isDataHazard=0. One cycle later, an instruction reading x5 -> BYPASS_MEMORY.
- lw x7 then dependent add x8,x7,x7 -> isDataHazard=1 for exactly 1 cycle, ex bubble, next cycle both ops BYPASS_MEMORY.
- Write to x0 followed by a reader of x0 -> NO_BYPASS, no hazard.
- EX branch with exPredTaken=0, exActualTaken=1 and a load-use pending in ID -> isBranchPredictMiss=1, isDataHazard=0, next cycle ex.valid=0. exPredTarget=0x100 vs exActualTarget=0x104, both taken -> mispredict=1.
- pipelineStall=1 for 3 cycles with a load in ex -> entries frozen, isDataHazard held 1, mispredict masked. Release -> normal advance.
- CONTROLLER_BYPASS_EN undefined: add x5, then reader of x5 -> isDataHazard=1 for 3 cycles, bypass always NO_BYPASS. Async rst low mid-stall -> outputs 0 immediately.
